sr_reg_bank: RTL and testbench
==============================

# sr_reg_bank

Parametrised bank of WIDTH clocked SR flip-flops with a selectable resolution for the S=R=1 (forbidden) input combination. It adds a global enable, per-bit sticky forbidden-input flags and a saturating event counter. It replaces discrete single-bit SR flip-flops wherever the design holds groups of set/reset status bits (interrupt pending bits, sticky status, handshake flags). All state updates on the rising edge of `clk`.

## Interface
Parameters:
- WIDTH, 8, number of SR bits in the bank (>=1).
- MODE, 0, S=R=1 resolution: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle. Values outside 0..3 are an elaboration error.
- RST_VAL, {WIDTH{1'b0}}, value loaded into `q` on reset.
- CNT_W, 8, width of the forbidden-event counter (>=2).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset; one clock, reset is synchronous and active-low.
- en  in  1  global update enable; 0 freezes all state.
- s  in  WIDTH  per-bit set request.
- r  in  WIDTH  per-bit reset request.
- err_clr  in  1  clears `err` and `err_cnt`.
- q  out  WIDTH  registered bit state.
- q_bar  out  WIDTH  always ~q.
- err  out  WIDTH  sticky per-bit flag: bit saw S=R=1 while en=1.
- any_err  out  1  |err.
- err_cnt  out  CNT_W  saturating count of cycles in which any bit saw S=R=1 with en=1.

## Operation
- Reset (rst_n=0 at an edge): q=RST_VAL, q_bar=~RST_VAL, err=0, any_err=0, err_cnt=0. Reset overrides en, s, r and err_clr.
- en=0: q, err and err_cnt hold. No forbidden events are recorded. err_clr is still honoured.
- en=1, per bit i:
  - s=0, r=0: hold.
  - s=0, r=1: q[i] becomes 0.
  - s=1, r=0: q[i] becomes 1.
  - s=1, r=1: MODE 0 hold, 1 becomes 1, 2 becomes 0, 3 becomes ~q[i]. In every mode the bit is a forbidden event.
- Forbidden vector f = s & r & {WIDTH{en}}.
- err update: err_next = (err_clr ? 0 : err) | f. A new event in the clear cycle is kept.
- err_cnt update:
  - err_clr=1: err_cnt becomes (|f ? 1 : 0).
  - err_clr=0 and |f: err_cnt increments by 1, saturating at 2^CNT_W-1. It never wraps.
  - Otherwise err_cnt holds.
  - Increment is one per cycle regardless of how many bits are forbidden.
- q_bar and any_err are combinational from registered q/err. No input-to-output combinational path exists.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on q/err/err_cnt after edge N.
- Reset asserted mid-operation takes effect at the next edge. The first update after deassertion is the first edge with rst_n=1.
- MODE 3 with s=r=1 held for k enabled cycles: q[i] alternates each cycle, and err_cnt advances by k (until saturation).
- Saturation: at err_cnt = all-ones, further events leave it all-ones. err stays set.

## Structure
- Package sr_pkg:
  - localparams SR_HOLD=0, SR_SETDOM=1, SR_RSTDOM=2, SR_TOGGLE=3.
  - function sr_next(q, s, r, mode), returning the next bit value.
- Sub-module sr_bit_cell: one bit, holding the q flop plus the sticky err flop. It is instantiated WIDTH times via generate and outputs f[i].
- Top level holds the err_cnt counter, the saturation logic and the any_err reduction.

## Test plan
- Reset: RST_VAL=4'b1010, WIDTH=4. Assert rst_n=0 for 2 cycles with s=4'hF -> q=4'b1010, q_bar=4'b0101, err=0, err_cnt=0.
- Basic per bit, MODE 0: en=1, s=4'b0011, r=4'b1100 -> q=4'b0011. Then s=r=0 for 3 cycles -> q holds 4'b0011, err=0.
- Forbidden resolution: from q=4'b0101, apply s=r=4'hF for one cycle. MODE 0 -> 4'b0101, MODE 1 -> 4'hF, MODE 2 -> 4'h0, MODE 3 -> 4'b1010. In all modes err=4'hF, any_err=1, err_cnt=1.
- Enable gating: en=0, s=r=4'hF for 5 cycles -> q, err, err_cnt unchanged. Then en=1 with s=4'b0001 -> q[0]=1 after one edge.
- Clear collision: err=4'b0001, err_cnt=3. Apply err_clr=1 with s=r=4'b0100 -> err=4'b0100, err_cnt=1. Next cycle err_clr=1 alone -> err=0, err_cnt=0.
- Saturation: CNT_W=2, MODE 3, s=r=1 on bit 0 for 6 cycles -> err_cnt reads 1,2,3,3,3,3 and q[0] toggles every cycle. Asserting reset mid-run -> next edge q=RST_VAL, err_cnt=0.

Source files
------------

// File: rtl/sr_pkg.sv
// Shared definitions for the SR register bank: forbidden-input resolution
// modes and the single-bit next-state function used by every bit cell.
package sr_pkg;

   localparam int SR_HOLD   = 0;
   localparam int SR_SETDOM = 1;
   localparam int SR_RSTDOM = 2;
   localparam int SR_TOGGLE = 3;

   // The four request combinations seen by one bit, encoded as {s, r}.
   typedef enum logic [1:0] {
      SR_IN_IDLE  = 2'b00,
      SR_IN_RESET = 2'b01,
      SR_IN_SET   = 2'b10,
      SR_IN_BOTH  = 2'b11
   } sr_in_e;

   // Next value of one SR bit for the given request and resolution mode.
   function automatic logic sr_next(input logic q, input logic s, input logic r, input int mode);
      sr_in_e req;
      logic   nxt;
      req = sr_in_e'({s, r});
      nxt = q;
      case (req)
         SR_IN_IDLE:  nxt = q;
         SR_IN_RESET: nxt = 1'b0;
         SR_IN_SET:   nxt = 1'b1;
         SR_IN_BOTH: begin
            case (mode)
               SR_SETDOM: nxt = 1'b1;
               SR_RSTDOM: nxt = 1'b0;
               SR_TOGGLE: nxt = ~q;
               default:   nxt = q;
            endcase
         end
         default: nxt = q;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/sr_bit_cell.sv
// One bit of the SR bank: the q flop, its sticky forbidden-input flag, and
// the combinational forbidden-event indication for the shared counter.
module sr_bit_cell
   import sr_pkg::*;
#(
   parameter int   MODE    = SR_HOLD,
   parameter logic RST_BIT = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic s,
   input  logic r,
   input  logic err_clr,
   output logic q,
   output logic err,
   output logic f
);

   // A forbidden event only counts while the bank is enabled.
   assign f = s & r & en;

   // Bit state and sticky flag; a new event in a clear cycle survives the clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q   <= RST_BIT;
         err <= 1'b0;
      end else begin
         if (en) begin
            q <= sr_next(q, s, r, MODE);
         end
         err <= (err_clr ? 1'b0 : err) | f;
      end
   end

endmodule

// File: rtl/sr_reg_bank.sv
// Parametrised bank of clocked SR flip-flops with selectable S=R=1
// resolution, sticky per-bit forbidden flags and a saturating event counter.
module sr_reg_bank
   import sr_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter int               MODE    = SR_HOLD,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
   parameter int               CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] r,
   input  logic             err_clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_bar,
   output logic [WIDTH-1:0] err,
   output logic             any_err,
   output logic [CNT_W-1:0] err_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Reject parameter values that have no meaning for this bank.
   generate
      if (MODE < SR_HOLD || MODE > SR_TOGGLE) begin : g_bad_mode
         $error("sr_reg_bank: MODE must be in 0..3");
      end
      if (WIDTH < 1) begin : g_bad_width
         $error("sr_reg_bank: WIDTH must be at least 1");
      end
      if (CNT_W < 2) begin : g_bad_cnt_w
         $error("sr_reg_bank: CNT_W must be at least 2");
      end
   endgenerate

   logic [WIDTH-1:0] f;
   logic             any_f;

   // One cell per bit; each cell owns its q and sticky err flops.
   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         sr_bit_cell #(
            .MODE    (MODE),
            .RST_BIT (RST_VAL[i])
         ) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .s       (s[i]),
            .r       (r[i]),
            .err_clr (err_clr),
            .q       (q[i]),
            .err     (err[i]),
            .f       (f[i])
         );
      end
   endgenerate

   assign q_bar   = ~q;
   assign any_err = |err;
   assign any_f   = |f;

   // Event counter: one step per cycle with any forbidden bit, sticks at all-ones,
   // and a clear cycle that also sees an event restarts at one rather than zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_cnt <= '0;
      end else if (err_clr) begin
         err_cnt <= any_f ? CNT_ONE : '0;
      end else if (any_f && (err_cnt != CNT_MAX)) begin
         err_cnt <= err_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_sr_reg_bank.sv
// Self-checking bench for sr_reg_bank: four 4-bit banks (one per resolution
// mode, 2-bit counter) plus one 8-bit bank, compared against a vector model.
module tb_sr_reg_bank;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       err_clr;
   logic [3:0] s4, r4;
   logic [7:0] s8, r8;

   logic [3:0] q_n[4], qb_n[4], err_n[4];
   logic       any_n[4];
   logic [1:0] cnt_n[4];

   logic [7:0] q_w, qb_w, err_w, cnt_w;
   logic       any_w;

   int vectors = 0;
   int miscompares = 0;

   // Model state and per-instance configuration (index 4 is the wide bank).
   logic [7:0] mq[5], merr[5];
   int         mcnt[5];
   int         cfg_mode[5] = '{0, 1, 2, 3, 1};
   int         cfg_max[5]  = '{3, 3, 3, 3, 255};
   logic [7:0] cfg_rst[5]  = '{8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'hC3};
   logic [7:0] cfg_mask[5] = '{8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'hFF};

   always #5 clk = ~clk;

   generate
      for (genvar g = 0; g < 4; g++) begin : g_dut
         sr_reg_bank #(
            .WIDTH   (4),
            .MODE    (g),
            .RST_VAL (4'b1010),
            .CNT_W   (2)
         ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .s       (s4),
            .r       (r4),
            .err_clr (err_clr),
            .q       (q_n[g]),
            .q_bar   (qb_n[g]),
            .err     (err_n[g]),
            .any_err (any_n[g]),
            .err_cnt (cnt_n[g])
         );
      end
   endgenerate

   sr_reg_bank #(
      .WIDTH   (8),
      .MODE    (1),
      .RST_VAL (8'hC3),
      .CNT_W   (8)
   ) u_wide (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .s       (s8),
      .r       (r8),
      .err_clr (err_clr),
      .q       (q_w),
      .q_bar   (qb_w),
      .err     (err_w),
      .any_err (any_w),
      .err_cnt (cnt_w)
   );

   // Packs the observable outputs of one instance as {q, q_bar, err, any_err, cnt}.
   function automatic logic [32:0] observed(input int k);
      if (k < 4) return {4'h0, q_n[k], 4'h0, qb_n[k], 4'h0, err_n[k], any_n[k], 6'h0, cnt_n[k]};
      return {q_w, qb_w, err_w, any_w, cnt_w};
   endfunction

   // Expected outputs of one instance derived from the model state.
   function automatic logic [32:0] expected(input int k);
      logic [7:0] c;
      c = 8'(mcnt[k]);
      return {mq[k], ~mq[k] & cfg_mask[k], merr[k], (merr[k] != 8'h00), c};
   endfunction

   // Whole-vector behavioural model of one clock edge for every instance.
   task automatic model_update(input logic rv, input logic ev, input logic cv,
                               input logic [7:0] sv, input logic [7:0] rvv);
      logic [7:0] sm, rm, both, only_s, only_r, res;
      for (int k = 0; k < 5; k++) begin
         if (!rv) begin
            mq[k] = cfg_rst[k];
            merr[k] = 8'h00;
            mcnt[k] = 0;
         end else begin
            sm = sv & cfg_mask[k];
            rm = rvv & cfg_mask[k];
            both = ev ? (sm & rm) : 8'h00;
            if (ev) begin
               only_s = sm & ~rm;
               only_r = rm & ~sm;
               case (cfg_mode[k])
                  1: res = both;
                  2: res = 8'h00;
                  3: res = ~mq[k] & both;
                  default: res = mq[k] & both;
               endcase
               mq[k] = ((mq[k] & ~(sm | rm)) | only_s | res) & ~only_r & cfg_mask[k];
            end
            merr[k] = (cv ? 8'h00 : merr[k]) | both;
            if (cv) mcnt[k] = (both != 0) ? 1 : 0;
            else if (both != 0) mcnt[k] = (mcnt[k] >= cfg_max[k]) ? cfg_max[k] : mcnt[k] + 1;
         end
      end
   endtask

   // Drive one cycle of inputs, advance the model at the edge, settle past it.
   task automatic applyStimulus(input logic rv, input logic ev, input logic cv,
                                input logic [7:0] sv, input logic [7:0] rvv);
      rst_n = rv; en = ev; err_clr = cv;
      s4 = sv[3:0]; r4 = rvv[3:0]; s8 = sv; r8 = rvv;
      @(posedge clk);
      model_update(rv, ev, cv, sv, rvv);
      #1;
   endtask

   task automatic test_reset();
      for (int c = 0; c < 2; c++) applyStimulus(1'b0, 1'b1, 1'b0, 8'hFF, 8'h00);
      for (int k = 0; k < 5; k++) begin
         vectors++;
         if (observed(k) !== expected(k)) begin
            miscompares++;
            $display("[TB] FAIL reset inst%0d: got %h expected %h", k, observed(k), expected(k));
         end
      end
      vectors++;
      if ({q_n[0], qb_n[0]} !== 8'b1010_0101) begin
         miscompares++;
         $display("[TB] FAIL reset_literal: got %b expected 10100101", {q_n[0], qb_n[0]});
      end
   endtask

   task automatic test_basic();
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h33, 8'hCC);
      for (int c = 0; c < 4; c++) begin
         if (c > 0) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
         for (int k = 0; k < 5; k++) begin
            vectors++;
            if (observed(k) !== expected(k)) begin
               miscompares++;
               $display("[TB] FAIL basic c%0d inst%0d: got %h expected %h", c, k, observed(k), expected(k));
            end
         end
      end
      vectors++;
      if (q_n[0] !== 4'b0011) begin
         miscompares++;
         $display("[TB] FAIL basic_literal: got %b expected 0011", q_n[0]);
      end
   endtask

   task automatic test_forbidden();
      logic [3:0] want[4] = '{4'b0101, 4'b1111, 4'b0000, 4'b1010};
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h55, 8'hAA);
      applyStimulus(1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF);
      for (int k = 0; k < 5; k++) begin
         vectors++;
         if (observed(k) !== expected(k)) begin
            miscompares++;
            $display("[TB] FAIL forbidden inst%0d: got %h expected %h", k, observed(k), expected(k));
         end
      end
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if ({q_n[k], err_n[k], any_n[k], cnt_n[k]} !== {want[k], 4'hF, 1'b1, 2'd1}) begin
            miscompares++;
            $display("[TB] FAIL forbidden_literal mode%0d: got q=%b cnt=%0d expected q=%b cnt=1", k, q_n[k], cnt_n[k], want[k]);
         end
      end
   endtask

   task automatic test_enable_gating();
      for (int c = 0; c < 5; c++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF);
         for (int k = 0; k < 5; k++) begin
            vectors++;
            if (observed(k) !== expected(k)) begin
               miscompares++;
               $display("[TB] FAIL gating c%0d inst%0d: got %h expected %h", c, k, observed(k), expected(k));
            end
         end
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h01, 8'h00);
      applyStimulus(1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF);
      for (int k = 0; k < 5; k++) begin
         vectors++;
         if (observed(k) !== expected(k)) begin
            miscompares++;
            $display("[TB] FAIL gating_clear inst%0d: got %h expected %h", k, observed(k), expected(k));
         end
      end
      vectors++;
      if (q_n[2][0] !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL gating_set_bit0: got %b expected 1", q_n[2][0]);
      end
   endtask

   task automatic test_clear_collision();
      for (int c = 0; c < 3; c++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h01, 8'h01);
      applyStimulus(1'b1, 1'b1, 1'b1, 8'h04, 8'h04);
      vectors++;
      if ({err_n[0], cnt_n[0]} !== {4'b0100, 2'd1}) begin
         miscompares++;
         $display("[TB] FAIL clear_collision: got err=%b cnt=%0d expected err=0100 cnt=1", err_n[0], cnt_n[0]);
      end
      applyStimulus(1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
      for (int k = 0; k < 5; k++) begin
         vectors++;
         if (observed(k) !== expected(k)) begin
            miscompares++;
            $display("[TB] FAIL clear_only inst%0d: got %h expected %h", k, observed(k), expected(k));
         end
      end
   endtask

   task automatic test_saturation();
      int seq[6] = '{1, 2, 3, 3, 3, 3};
      logic prev;
      prev = q_n[3][0];
      for (int c = 0; c < 6; c++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 8'h01, 8'h01);
         vectors++;
         if (cnt_n[3] !== 2'(seq[c]) || q_n[3][0] !== ~prev) begin
            miscompares++;
            $display("[TB] FAIL saturation c%0d: got cnt=%0d q0=%b expected cnt=%0d q0=%b", c, cnt_n[3], q_n[3][0], seq[c], ~prev);
         end
         prev = ~prev;
         for (int k = 0; k < 5; k++) begin
            vectors++;
            if (observed(k) !== expected(k)) begin
               miscompares++;
               $display("[TB] FAIL saturation_model c%0d inst%0d: got %h expected %h", c, k, observed(k), expected(k));
            end
         end
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h01, 8'h01);
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
      for (int k = 0; k < 5; k++) begin
         vectors++;
         if (observed(k) !== expected(k)) begin
            miscompares++;
            $display("[TB] FAIL midrun_reset inst%0d: got %h expected %h", k, observed(k), expected(k));
         end
      end
   endtask

   task automatic test_random();
      logic rv, ev, cv;
      logic [7:0] sv, rvv;
      for (int c = 0; c < 300; c++) begin
         rv  = ($urandom_range(0, 39) != 0);
         ev  = ($urandom_range(0, 3) != 0);
         cv  = ($urandom_range(0, 9) == 0);
         sv  = 8'($urandom);
         rvv = 8'($urandom);
         applyStimulus(rv, ev, cv, sv, rvv);
         for (int k = 0; k < 5; k++) begin
            vectors++;
            if (observed(k) !== expected(k)) begin
               miscompares++;
               $display("[TB] FAIL random c%0d inst%0d: got %h expected %h", c, k, observed(k), expected(k));
            end
         end
      end
   endtask

   // Scenario sequence followed by the single summary line.
   initial begin
      rst_n = 1'b0; en = 1'b0; err_clr = 1'b0;
      s4 = '0; r4 = '0; s8 = '0; r8 = '0;
      for (int k = 0; k < 5; k++) begin
         mq[k] = 8'h00; merr[k] = 8'h00; mcnt[k] = 0;
      end
      test_reset();
      test_basic();
      test_forbidden();
      test_enable_gating();
      test_clear_collision();
      test_saturation();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
